// File: rtl/noc_pkg.sv
// noc_pkg: flit encodings and requester FSM state shared
// by the port requesters, the switch arbiter and its timer.
package noc_pkg;

  localparam logic [2:0] FLIT_NONE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  localparam int LEN_W = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } req_state_t;

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: small synchronous FIFO, no bypass.
// Head is valid one cycle after the push that wrote it.
module flit_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/port_requester.sv
// port_requester: buffers one router input port, requests the
// switch arbiter and forwards the granted packet flit by flit.
module port_requester
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  input  logic              grant,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int FW = DATA_W + 3;

  logic              push, pop, full, empty;
  logic [FW-1:0]     head;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;
  logic              pop_fwd, pop_drop;

  req_state_t       state_q, state_d;
  logic             req_q, req_d;
  logic [LEN_W-1:0] len_q, len_d;

  assign push = in_valid && !full;
  assign pop  = pop_fwd || pop_drop;

  flit_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_flit_id, in_data}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_id   = head[FW-1 -: 3];
  assign head_data = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && head_id == FLIT_HEAD) begin
          state_d = S_REQ;
          len_d   = head_data[LEN_W-1:0];
        end
      end
      S_REQ: begin
        if (pop_fwd) state_d = S_SEND;
      end
      S_SEND: begin
        if (pop_fwd && head_id == FLIT_TAIL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d != S_IDLE);
  end

  // A header seen mid-packet is dropped like a stray in IDLE.
  always_comb begin
    pop_fwd  = 1'b0;
    pop_drop = 1'b0;
    if (!rst && !empty) begin
      unique case (state_q)
        S_IDLE: pop_drop = (head_id != FLIT_HEAD);
        S_REQ:  pop_fwd  = grant;
        S_SEND: begin
          pop_drop = grant && (head_id == FLIT_HEAD);
          pop_fwd  = grant && (head_id != FLIT_HEAD);
        end
        default: pop_fwd = 1'b0;
      endcase
    end
  end

  assign in_ready    = !full;
  assign req         = req_q;
  assign length      = len_q;
  assign flit_id     = empty ? FLIT_NONE : head_id;
  assign out_valid   = pop_fwd;
  assign out_flit_id = head_id;
  assign out_data    = head_data;
  assign err         = pop_drop;

endmodule

// File: tb/tb_port_requester.sv
// tb_port_requester: directed scenarios plus a randomized run
// scored against a packet-level filter model.
module tb_port_requester;
  import noc_pkg::*;

  localparam logic [2:0] H = FLIT_HEAD;
  localparam logic [2:0] B = FLIT_BODY;
  localparam logic [2:0] T = FLIT_TAIL;
  localparam logic [2:0] Z = FLIT_NONE;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_flit_id;
  logic [31:0] in_data;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        grant;
  logic        out_valid;
  logic [2:0]  out_flit_id;
  logic [31:0] out_data;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  port_requester #(.DATA_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_flit_id  (in_flit_id),
    .in_data     (in_data),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_flit_id (out_flit_id),
    .out_data    (out_data),
    .err         (err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    grant = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_flit_id = Z;
    in_data = '0;
    grant = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req, out_valid, err, in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset.ctrl got=%b exp=0001", {req, out_valid, err, in_ready});
    end
    checks++;
    if ({flit_id, length} !== 15'd0) begin
      failures++;
      $display("FAIL reset.ids flit_id=%b length=%0d exp 000/0", flit_id, length);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [2:0] iid[8] = '{H, B, B, T, Z, Z, Z, Z};
    logic       er[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [2:0] eo[8]  = '{Z, Z, H, B, B, T, Z, Z};
    int         es[8]  = '{-1, -1, 0, 1, 2, 3, -1, -1};
    logic [31:0] dat[8];
    foreach (dat[i]) dat[i] = $urandom;
    dat[0][11:0] = 12'd20;
    quiet_reset();
    for (int c = 0; c < 8; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = 1'b1;
      @(negedge clk);
      checks++;
      if (req !== er[c]) begin
        failures++;
        $display("FAIL basic.req c%0d got=%b exp=%b", c, req, er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z) || err !== 1'b0) begin
        failures++;
        $display("FAIL basic.valid c%0d got=%b/%b exp=%b/0", c, out_valid, err, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL basic.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      if (c == 2) begin
        checks++;
        if (length !== 12'd20) begin
          failures++;
          $display("FAIL basic.length got=%0d exp=20", length);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_grant_gap();
    logic [2:0] iid[11] = '{H, B, B, T, Z, Z, Z, Z, Z, Z, Z};
    logic       g[11]   = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic       er[11]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [2:0] eo[11]  = '{Z, Z, H, Z, Z, Z, B, B, T, Z, Z};
    int         es[11]  = '{-1, -1, 0, -1, -1, -1, 1, 2, 3, -1, -1};
    logic [31:0] dat[11];
    foreach (dat[i]) dat[i] = $urandom;
    quiet_reset();
    for (int c = 0; c < 11; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = g[c];
      @(negedge clk);
      checks++;
      if (req !== er[c]) begin
        failures++;
        $display("FAIL gap.req c%0d got=%b exp=%b", c, req, er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z)) begin
        failures++;
        $display("FAIL gap.valid c%0d got=%b exp=%b", c, out_valid, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL gap.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fifo_full();
    logic [2:0] iid[11] = '{H, B, B, T, H, Z, Z, Z, Z, Z, Z};
    logic       g[11]   = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic       er[11]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       ir[11]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    logic [2:0] eo[11]  = '{Z, Z, Z, Z, Z, H, B, B, T, Z, Z};
    int         es[11]  = '{-1, -1, -1, -1, -1, 0, 1, 2, 3, -1, -1};
    logic [31:0] dat[11];
    foreach (dat[i]) dat[i] = $urandom;
    quiet_reset();
    for (int c = 0; c < 11; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = g[c];
      @(negedge clk);
      checks++;
      if (in_ready !== ir[c] || req !== er[c]) begin
        failures++;
        $display("FAIL full.ready_req c%0d got=%b/%b exp=%b/%b", c, in_ready, req, ir[c], er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z)) begin
        failures++;
        $display("FAIL full.valid c%0d got=%b exp=%b", c, out_valid, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL full.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      if (c >= 9) begin
        checks++;
        if (flit_id !== Z) begin
          failures++;
          $display("FAIL full.empty_after c%0d flit_id=%b exp=000", c, flit_id);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stray();
    logic [2:0] iid[7] = '{B, H, T, Z, Z, Z, Z};
    logic       er[7]  = '{0, 0, 0, 1, 1, 0, 0};
    logic       ee[7]  = '{0, 1, 0, 0, 0, 0, 0};
    logic [2:0] eo[7]  = '{Z, Z, Z, H, T, Z, Z};
    int         es[7]  = '{-1, -1, -1, 1, 2, -1, -1};
    logic [31:0] dat[7];
    foreach (dat[i]) dat[i] = $urandom;
    quiet_reset();
    for (int c = 0; c < 7; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = 1'b1;
      @(negedge clk);
      checks++;
      if (err !== ee[c] || req !== er[c]) begin
        failures++;
        $display("FAIL stray.err_req c%0d got=%b/%b exp=%b/%b", c, err, req, ee[c], er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z)) begin
        failures++;
        $display("FAIL stray.valid c%0d got=%b exp=%b", c, out_valid, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL stray.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] iid[10] = '{H, B, B, T, Z, H, T, Z, Z, Z};
    logic       rs[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic       er[10]  = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    logic [2:0] eo[10]  = '{Z, Z, H, B, Z, Z, Z, H, T, Z};
    int         es[10]  = '{-1, -1, 0, 1, -1, -1, -1, 5, 6, -1};
    logic [31:0] dat[10];
    foreach (dat[i]) dat[i] = $urandom;
    quiet_reset();
    for (int c = 0; c < 10; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = 1'b1; rst = rs[c];
      @(negedge clk);
      checks++;
      if (req !== er[c]) begin
        failures++;
        $display("FAIL rstmid.req c%0d got=%b exp=%b", c, req, er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z)) begin
        failures++;
        $display("FAIL rstmid.valid c%0d got=%b exp=%b", c, out_valid, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL rstmid.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      if (c == 5) begin
        checks++;
        if ({flit_id, in_ready, length} !== {Z, 1'b1, 12'd0}) begin
          failures++;
          $display("FAIL rstmid.cleared flit_id=%b in_ready=%b length=%0d exp 000/1/0", flit_id, in_ready, length);
        end
      end
      if (c == 7) begin
        checks++;
        if (length !== dat[5][11:0]) begin
          failures++;
          $display("FAIL rstmid.length got=%0d exp=%0d", length, dat[5][11:0]);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] iid[8] = '{H, T, H, T, Z, Z, Z, Z};
    logic       er[8]  = '{0, 0, 1, 1, 0, 1, 1, 0};
    logic [2:0] eo[8]  = '{Z, Z, H, T, Z, H, T, Z};
    int         es[8]  = '{-1, -1, 0, 1, -1, 2, 3, -1};
    logic [31:0] dat[8];
    foreach (dat[i]) dat[i] = $urandom;
    quiet_reset();
    for (int c = 0; c < 8; c++) begin
      in_valid = (iid[c] != Z); in_flit_id = iid[c];
      in_data = dat[c]; grant = 1'b1;
      @(negedge clk);
      checks++;
      if (req !== er[c]) begin
        failures++;
        $display("FAIL b2b.req c%0d got=%b exp=%b", c, req, er[c]);
      end
      checks++;
      if (out_valid !== (eo[c] != Z)) begin
        failures++;
        $display("FAIL b2b.valid c%0d got=%b exp=%b", c, out_valid, eo[c] != Z);
      end else if (eo[c] != Z) begin
        checks++;
        if ({out_flit_id, out_data} !== {eo[c], dat[es[c]]}) begin
          failures++;
          $display("FAIL b2b.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, eo[c], dat[es[c]]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [34:0] gen_q[$];
    logic [34:0] exp_q[$];
    logic [34:0] f;
    bit inpkt = 0;
    int strays = 0, errs = 0, occ = 0, nb;
    while (gen_q.size() < 600) begin
      if ($urandom_range(5) == 0) begin
        gen_q.push_back({($urandom_range(1) != 0) ? B : T, 32'($urandom)});
      end else begin
        gen_q.push_back({H, 32'($urandom)});
        nb = $urandom_range(3);
        for (int i = 0; i < nb; i++) begin
          if ($urandom_range(9) == 0) gen_q.push_back({H, 32'($urandom)});
          gen_q.push_back({B, 32'($urandom)});
        end
        gen_q.push_back({T, 32'($urandom)});
      end
    end
    quiet_reset();
    for (int c = 0; c < 8000 && (gen_q.size() != 0 || occ != 0); c++) begin
      f = (gen_q.size() != 0) ? gen_q[0] : '0;
      in_valid = (gen_q.size() != 0) && ($urandom_range(3) != 0);
      {in_flit_id, in_data} = f;
      grant = (gen_q.size() == 0) || ($urandom_range(3) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (occ < 4) || (flit_id == Z) !== (occ == 0)) begin
        failures++;
        $display("FAIL rand.occupancy c%0d in_ready=%b flit_id=%b exp_occ=%0d", c, in_ready, flit_id, occ);
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0 || !grant || !req || err) begin
          failures++;
          $display("FAIL rand.spurious c%0d grant=%b req=%b err=%b pending=%0d", c, grant, req, err, exp_q.size());
        end else if ({out_flit_id, out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL rand.flit c%0d got=%b/%h exp=%b/%h", c, out_flit_id, out_data, exp_q[0][34:32], exp_q[0][31:0]);
        end else if (out_flit_id == H) begin
          checks++;
          if (length !== out_data[11:0]) begin
            failures++;
            $display("FAIL rand.length c%0d got=%0d exp=%0d", c, length, out_data[11:0]);
          end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        occ--;
      end
      if (err) begin
        errs++;
        occ--;
      end
      if (in_valid && in_ready) begin
        if (f[34:32] == H) begin
          if (inpkt) strays++;
          else begin exp_q.push_back(f); inpkt = 1; end
        end else if (f[34:32] == T) begin
          if (inpkt) begin exp_q.push_back(f); inpkt = 0; end
          else strays++;
        end else begin
          if (inpkt) exp_q.push_back(f);
          else strays++;
        end
        void'(gen_q.pop_front());
        occ++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (gen_q.size() != 0 || occ != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand.drain left_gen=%0d occ=%0d pending=%0d exp 0", gen_q.size(), occ, exp_q.size());
    end
    checks++;
    if (errs != strays) begin
      failures++;
      $display("FAIL rand.err_count got=%0d exp=%0d", errs, strays);
    end
    checks++;
    if (req !== 1'b0) begin
      failures++;
      $display("FAIL rand.final_req got=%b exp=0", req);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_gap();
    test_fifo_full();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
